// File: rtl/ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit
//
// Iterative multiply/divide unit for the EX stage. It processes one bit per
// cycle for MULT/MULTU/DIV/DIVU and owns the architectural HI/LO registers.
// While it is busy it asks the hazard logic to stall any instruction that
// would touch HI/LO or start another mul/div.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous, active-high reset
//   i_start        mul/div op valid in EX this cycle
//   i_op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_data1        rs value: multiplicand / dividend / mthi-mtlo source
//   i_data2        rt value: multiplier / divisor
//   i_mthi         write i_data1 to HI (accepted only when idle)
//   i_mtlo         write i_data1 to LO (accepted only when idle)
//   i_hilo_read    mfhi/mflo in EX this cycle (only affects the stall)
//   o_hi, o_lo     HI and LO registers
//   o_busy         an operation is in progress
//   o_stall        freeze PC/IF-ID/ID-EX this cycle
//   o_done         one-cycle pulse when a mul/div result lands in HI/LO
//   o_div_by_zero  pulses with o_done when the divisor was zero
// ----------------------------------------------------------------------------
module ex_muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_data1,
    input  logic [DATA_W-1:0] i_data2,
    input  logic              i_mthi,
    input  logic              i_mtlo,
    input  logic              i_hilo_read,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo,
    output logic              o_busy,
    output logic              o_stall,
    output logic              o_done,
    output logic              o_div_by_zero
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     a_q, a_d;
    logic [DATA_W-1:0]     b_q, b_d;
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    logic                  neg_res_q, neg_res_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  is_div_q, is_div_d;
    logic                  dz_q, dz_d;
    logic [DATA_W-1:0]     hi_q, hi_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic                  done_q, done_d;
    logic                  dz_pulse_q, dz_pulse_d;

    // Operand sign/magnitude extraction; unsigned ops (op[0]=1) never negate.
    logic                  signed_op;
    logic                  s1, s2;
    logic [DATA_W-1:0]     mag1, mag2;

    assign signed_op = ~i_op[0];
    assign s1        = signed_op & i_data1[DATA_W-1];
    assign s2        = signed_op & i_data2[DATA_W-1];
    assign mag1      = s1 ? (~i_data1 + 1'b1) : i_data1;
    assign mag2      = s2 ? (~i_data2 + 1'b1) : i_data2;

    // Datapath scratch values used by the iteration and fix-up states.
    logic [2*DATA_W-1:0]   mul_add;
    logic [DATA_W:0]       rem_shift;
    logic [DATA_W:0]       rem_sub;
    logic [2*DATA_W-1:0]   prod_fix;

    // Next-state and datapath logic. The multiplier is consumed MSB first
    // (shift accumulator left, add multiplicand when the bit is set); the
    // divider is restoring, with the accumulator holding {remainder, quotient}
    // and the dividend shifted out of a_q one bit per cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        is_div_d   = is_div_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dz_pulse_d = 1'b0;
        mul_add    = '0;
        rem_shift  = '0;
        rem_sub    = '0;
        prod_fix   = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    acc_d     = '0;
                    cnt_d     = '0;
                    is_div_d  = i_op[1];
                    neg_res_d = s1 ^ s2;
                    neg_rem_d = s1;
                    a_d       = mag1;
                    b_d       = mag2;
                    dz_d      = 1'b0;
                    if (!i_op[1]) begin
                        state_d = ST_MUL;
                    end else if (i_data2 == '0) begin
                        // Divide by zero skips iteration; HI reports the raw dividend.
                        state_d = ST_FIX;
                        dz_d    = 1'b1;
                        a_d     = i_data1;
                    end else begin
                        state_d = ST_DIV;
                    end
                end else if (i_mthi) begin
                    hi_d = i_data1;
                end else if (i_mtlo) begin
                    lo_d = i_data1;
                end
            end

            ST_MUL: begin
                mul_add = b_q[DATA_W-1] ? {{DATA_W{1'b0}}, a_q} : '0;
                acc_d   = {acc_q[2*DATA_W-2:0], 1'b0} + mul_add;
                b_d     = {b_q[DATA_W-2:0], 1'b0};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = ST_FIX;
                end
            end

            ST_DIV: begin
                rem_shift = {acc_q[2*DATA_W-1:DATA_W], a_q[DATA_W-1]};
                rem_sub   = rem_shift - {1'b0, b_q};
                // A clear borrow bit means the shifted remainder was >= divisor.
                if (!rem_sub[DATA_W]) begin
                    acc_d = {rem_sub[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                end else begin
                    acc_d = {rem_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
                end
                a_d   = {a_q[DATA_W-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                if (dz_q) begin
                    lo_d       = '1;
                    hi_d       = a_q;
                    dz_pulse_d = 1'b1;
                end else if (is_div_q) begin
                    lo_d = neg_res_q ? (~acc_q[DATA_W-1:0] + 1'b1)
                                     : acc_q[DATA_W-1:0];
                    hi_d = neg_rem_q ? (~acc_q[2*DATA_W-1:DATA_W] + 1'b1)
                                     : acc_q[2*DATA_W-1:DATA_W];
                end else begin
                    prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
                    hi_d     = prod_fix[2*DATA_W-1:DATA_W];
                    lo_d     = prod_fix[DATA_W-1:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            is_div_q   <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dz_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            is_div_q   <= is_div_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            dz_pulse_q <= dz_pulse_d;
        end
    end

    assign o_hi          = hi_q;
    assign o_lo          = lo_q;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_stall       = o_busy & (i_start | i_hilo_read | i_mthi | i_mtlo);
    assign o_done        = done_q;
    assign o_div_by_zero = dz_pulse_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv_unit
//
// Self-checking bench for ex_muldiv_unit (DATA_W = 32). A table of mul/div
// vectors is run through a scoreboard queue, followed by hand-written
// sequences for stalling, back-to-back ops, reset mid-operation and mthi/mtlo.
// ----------------------------------------------------------------------------
module tb_ex_muldiv_unit;

   localparam int W = 32;
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   logic         clk;
   logic         rst;
   logic         iStart;
   logic [1:0]   iOp;
   logic [W-1:0] iData1;
   logic [W-1:0] iData2;
   logic         iMthi;
   logic         iMtlo;
   logic         iHiloRead;
   logic [W-1:0] oHi;
   logic [W-1:0] oLo;
   logic         oBusy;
   logic         oStall;
   logic         oDone;
   logic         oDivByZero;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] d1;
      logic [W-1:0] d2;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           lat;
   } vec_t;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } exp_t;

   vec_t vecs[10];
   exp_t sbq[$];

   int nCompared;
   int nMismatched;

   // Reference HI/LO as the bench believes they should currently be.
   logic [W-1:0] modelHi;
   logic [W-1:0] modelLo;

   ex_muldiv_unit #(.DATA_W(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_start       (iStart),
      .i_op          (iOp),
      .i_data1       (iData1),
      .i_data2       (iData2),
      .i_mthi        (iMthi),
      .i_mtlo        (iMtlo),
      .i_hilo_read   (iHiloRead),
      .o_hi          (oHi),
      .o_lo          (oLo),
      .o_busy        (oBusy),
      .o_stall       (oStall),
      .o_done        (oDone),
      .o_div_by_zero (oDivByZero)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts and reports every check.
   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one mul/div at the current negedge, push its expected result and
   // return at the negedge right after the accepting edge.
   task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] d1, input logic [W-1:0] d2,
                                input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz);
      exp_t e;
      iOp    = op;
      iData1 = d1;
      iData2 = d2;
      iStart = 1'b1;
      e.hi = hi;
      e.lo = lo;
      e.dz = dz;
      sbq.push_back(e);
      #1;
      checkVal("stall_when_idle", {63'd0, oStall}, 64'd0);
      @(negedge clk);
      iStart = 1'b0;
   endtask

   // Wait (bounded) for o_done and check the latency and busy release.
   task automatic waitDone(input string name, input int expLat);
      int cycles;
      cycles = 0;
      while (!oDone && cycles < 200) begin
         @(negedge clk);
         cycles++;
      end
      checkVal({name, "_latency"}, 64'(cycles), 64'(expLat));
      checkVal({name, "_busy_at_done"}, {63'd0, oBusy}, 64'd0);
   endtask

   // Pop the oldest expected result and compare HI/LO/div-by-zero flag.
   task automatic checkOutput(input string name);
      exp_t e;
      if (sbq.size() == 0) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL %s_scoreboard: got empty queue, expected an entry", name);
      end else begin
         e = sbq.pop_front();
         checkVal({name, "_hi"}, {32'd0, oHi}, {32'd0, e.hi});
         checkVal({name, "_lo"}, {32'd0, oLo}, {32'd0, e.lo});
         checkVal({name, "_dz"}, {63'd0, oDivByZero}, {63'd0, e.dz});
         modelHi = e.hi;
         modelLo = e.lo;
      end
   endtask

   initial begin
      int stallBad;
      int hiloBad;
      int doneSeen;
      int cycles;
      exp_t e;

      nCompared   = 0;
      nMismatched = 0;
      modelHi     = '0;
      modelLo     = '0;

      vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
      vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33};
      vecs[2] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33};
      vecs[3] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
      vecs[4] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33};
      vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33};
      vecs[6] = '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 1};
      vecs[7] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 33};
      vecs[8] = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 33};
      vecs[9] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0, 33};

      rst       = 1'b1;
      iStart    = 1'b0;
      iOp       = 2'b00;
      iData1    = '0;
      iData2    = '0;
      iMthi     = 1'b0;
      iMtlo     = 1'b0;
      iHiloRead = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk);
      checkVal("reset_hi",   {32'd0, oHi}, 64'd0);
      checkVal("reset_lo",   {32'd0, oLo}, 64'd0);
      checkVal("reset_busy", {63'd0, oBusy}, 64'd0);
      checkVal("reset_done", {63'd0, oDone}, 64'd0);
      checkVal("reset_dz",   {63'd0, oDivByZero}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Table-driven mul/div vectors.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].op, vecs[i].d1, vecs[i].d2, vecs[i].hi, vecs[i].lo, vecs[i].dz);
         checkVal($sformatf("vec%0d_busy_after_start", i), {63'd0, oBusy}, 64'd1);
         waitDone($sformatf("vec%0d", i), vecs[i].lat);
         checkOutput($sformatf("vec%0d", i));
         @(negedge clk);
         checkVal($sformatf("vec%0d_done_single", i), {63'd0, oDone}, 64'd0);
      end

      // Stall on a HI/LO read, then hold a second op upstream until idle.
      applyStimulus(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
      iHiloRead = 1'b1;
      #1;
      checkVal("stall_hilo_read", {63'd0, oStall}, 64'd1);
      @(negedge clk);
      iHiloRead = 1'b0;
      iOp       = OP_MULT;
      iData1    = 32'hFFFF_FFFE;
      iData2    = 32'd3;
      iStart    = 1'b1;
      stallBad  = 0;
      hiloBad   = 0;
      cycles    = 1;
      while (!oDone && cycles < 200) begin
         #1;
         if (oBusy && !oStall) stallBad++;
         if (oBusy && (oHi !== modelHi || oLo !== modelLo)) hiloBad++;
         @(negedge clk);
         cycles++;
      end
      checkVal("stall_held_latency", 64'(cycles), 64'd33);
      checkVal("stall_held_every_cycle", 64'(stallBad), 64'd0);
      checkVal("hilo_stable_while_busy", 64'(hiloBad), 64'd0);
      checkOutput("stall_first_op");
      checkVal("stall_released_idle", {63'd0, oStall}, 64'd0);
      e.hi = 32'hFFFF_FFFF;
      e.lo = 32'hFFFF_FFFA;
      e.dz = 1'b0;
      sbq.push_back(e);
      @(negedge clk);
      iStart = 1'b0;
      checkVal("second_op_accepted", {63'd0, oBusy}, 64'd1);
      waitDone("second_op", 33);
      checkOutput("second_op");

      // Reset at iteration 10 of a divide discards the result.
      @(negedge clk);
      iOp    = OP_DIVU;
      iData1 = 32'd100;
      iData2 = 32'd7;
      iStart = 1'b1;
      @(negedge clk);
      iStart = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkVal("midreset_busy", {63'd0, oBusy}, 64'd0);
      checkVal("midreset_hi",   {32'd0, oHi}, 64'd0);
      checkVal("midreset_lo",   {32'd0, oLo}, 64'd0);
      modelHi  = '0;
      modelLo  = '0;
      doneSeen = 0;
      for (int c = 0; c < 40; c++) begin
         if (oDone) doneSeen++;
         @(negedge clk);
      end
      checkVal("midreset_no_done", 64'(doneSeen), 64'd0);

      // mthi / mtlo in idle, including their priority.
      iData1 = 32'h0000_1234;
      iMthi  = 1'b1;
      @(negedge clk);
      iMthi = 1'b0;
      checkVal("mthi_hi", {32'd0, oHi}, 64'h1234);
      checkVal("mthi_lo", {32'd0, oLo}, 64'd0);
      iData1 = 32'h0000_ABCD;
      iMtlo  = 1'b1;
      @(negedge clk);
      iMtlo = 1'b0;
      checkVal("mtlo_lo", {32'd0, oLo}, 64'hABCD);
      checkVal("mtlo_hi", {32'd0, oHi}, 64'h1234);
      iData1 = 32'h0000_5555;
      iMthi  = 1'b1;
      iMtlo  = 1'b1;
      @(negedge clk);
      iMthi = 1'b0;
      iMtlo = 1'b0;
      checkVal("mthi_over_mtlo_hi", {32'd0, oHi}, 64'h5555);
      checkVal("mthi_over_mtlo_lo", {32'd0, oLo}, 64'hABCD);

      // Start wins over mthi; a held mthi is then stalled and ignored while busy.
      iMthi = 1'b1;
      applyStimulus(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
      #1;
      checkVal("start_over_mthi_hi", {32'd0, oHi}, 64'h5555);
      checkVal("mthi_busy_stall", {63'd0, oStall}, 64'd1);
      @(negedge clk);
      iMthi = 1'b0;
      checkVal("mthi_busy_ignored", {32'd0, oHi}, 64'h5555);
      waitDone("start_mthi_op", 32);
      checkOutput("start_mthi_op");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage. Consumes the operand and control outputs of the ID/EX pipeline register.
- Performs MULT/MULTU/DIV/DIVU one bit per cycle and owns the architectural HI/LO registers.
- Raises a stall to the hazard/stall logic while busy, so dependent HI/LO reads and back-to-back mul/div ops wait upstream.

Parameters:
DATA_W, 32, operand and HI/LO width (matches `LEN_DATA)

Ports:
clk  input  1  system clock, posedge
rst  input  1  synchronous, active-high reset
i_start  input  1  mul/div op valid in EX this cycle
i_op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
i_data1  input  DATA_W  rs value (post-forwarding); dividend/multiplicand; mthi/mtlo source
i_data2  input  DATA_W  rt value (post-forwarding); divisor/multiplier
i_mthi  input  1  write i_data1 to HI
i_mtlo  input  1  write i_data1 to LO
i_hilo_read  input  1  mfhi/mflo in EX this cycle
o_hi  output  DATA_W  HI register
o_lo  output  DATA_W  LO register
o_busy  output  1  operation in progress
o_stall  output  1  freeze PC/IF-ID/ID-EX this cycle
o_done  output  1  one-cycle pulse when HI/LO updated by mul/div
o_div_by_zero  output  1  pulses with o_done when divisor was 0

Behaviour:
- Reset (rst=1 at posedge, including mid-operation): state=IDLE, counter=0, o_hi=o_lo=0, o_done=0, o_div_by_zero=0. Any in-flight result is discarded.
- States:
  - IDLE: no operation.
  - MUL: shift-add multiply on magnitudes.
  - DIV: restoring divide on magnitudes.
  - FIX: apply signs, write HI/LO.
- o_busy = (state != IDLE), decoded from registered state.
- o_stall = o_busy & (i_start | i_hilo_read | i_mthi | i_mtlo). Combinational; no stall when idle.
- Acceptance, at an edge with state=IDLE and i_start=1:
  - For signed ops, latch |i_data1| and |i_data2|; record result signs: product = s1^s2, quotient = s1^s2, remainder = s1.
  - Clear the 2*DATA_W accumulator; counter=0.
  - state -> MUL for op[1]=0, else -> DIV.
  - DIV with i_data2==0: state -> FIX directly with the dz flag set.
- i_start while busy is ignored; the stall holds the instruction upstream until IDLE.
- MUL/DIV: one iteration per edge, counter++. The edge with counter==DATA_W-1 moves state -> FIX. That is DATA_W iteration edges in total.
- FIX edge:
  - Negate the result per recorded sign (two's complement, truncated to DATA_W).
  - Mul: HI=upper, LO=lower.
  - Div: LO=quotient, HI=remainder.
  - Div-by-zero: LO=all ones, HI=i_data1 as latched; o_div_by_zero=1.
  - o_done=1 for this one cycle; state -> IDLE.
- Latency:
  - Start accepted at edge 0; HI/LO valid and o_done high after edge DATA_W+1 (33 for DATA_W=32).
  - Div-by-zero: after edge 1.
  - o_busy deasserts in the same cycle o_done asserts.
- Overflow rules:
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no flag).
  - MULT 0x80000000*0x80000000 gives HI=0x40000000, LO=0.
- mthi/mtlo are accepted only in IDLE; the write takes effect at that edge. Priority when asserted together in IDLE: i_start > i_mthi > i_mtlo.
- o_hi/o_lo hold their values during an operation; they change only at FIX, at an mthi/mtlo edge, or at reset.
- i_hilo_read has no side effects; the read mux lives outside this block.

Test Plan:
- Reset, then MULTU 0xFFFFFFFF*0xFFFFFFFF -> o_busy for 33 cycles, then o_done pulse; HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD(-3)*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- DIVU 5/0 -> o_done and o_div_by_zero high after edge 1; LO=0xFFFFFFFF, HI=5.
- During MUL, assert i_hilo_read, then i_start -> o_stall=1 each cycle; second op accepted only at the first IDLE edge; HI/LO unchanged until FIX.
- rst at iteration 10 of DIV -> next cycle state IDLE, HI=LO=0, no o_done. Then mthi 0x1234 in IDLE -> HI=0x1234 next cycle.
